// File: rtl/booth_multiplier.sv
// Sequential radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product,
// signed or unsigned per operation, WIDTH/2+1 cycles per result.
module booth_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Done,
  output logic               Busy
);

  localparam int unsigned XW = WIDTH + 2;  // extended operand width
  localparam int unsigned UW = WIDTH + 4;  // upper accumulator width, holds +-2M
  localparam int unsigned N  = WIDTH / 2 + 1;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e             state_q, state_d;
  logic [XW-1:0]      mcand_q, mcand_d;
  logic [XW-1:0]      mul_q, mul_d;
  logic               prev_q, prev_d;
  logic [UW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [UW-1:0] m_ext, m_dbl, pp, acc_sum;
  logic [2:0]    window;

  always_comb begin
    m_ext  = {{2{mcand_q[XW-1]}}, mcand_q};
    m_dbl  = {m_ext[UW-2:0], 1'b0};
    window = {mul_q[1:0], prev_q};
    case (window)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_dbl;
      3'b100:         pp = -m_dbl;
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mul_d     = mul_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          mcand_d = Signed_Mode ? {{2{Multiplicand[WIDTH-1]}}, Multiplicand}
                                : {2'b00, Multiplicand};
          mul_d   = Signed_Mode ? {{2{Multiplier[WIDTH-1]}}, Multiplier}
                                : {2'b00, Multiplier};
          prev_d  = 1'b0;
          acc_d   = '0;
          count_d = CW'(N);
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Arithmetic shift right by 2 across {acc, mul, prev}
        acc_d   = {{2{acc_sum[UW-1]}}, acc_sum[UW-1:2]};
        mul_d   = {acc_sum[1:0], mul_q[XW-1:2]};
        prev_d  = mul_q[1];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          // All XW multiplier bits consumed: low product bits sit in mul
          product_d = {acc_d[WIDTH-3:0], mul_d};
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mul_q     <= '0;
      prev_q    <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mul_q     <= mul_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign Product = product_q;
  assign Done    = done_q;
  assign Busy    = (state_q == StCalc);

endmodule

// File: tb/tb_booth_multiplier.sv
// Bench for booth_multiplier: directed vectors, random operands against an
// arithmetic reference, and multi-cycle corner sequences on WIDTH=16 and 8.
module tb_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] prod16;
  logic        done16, busy16;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;
  logic        done8, busy8;

  int passed = 0;
  int total  = 0;

  booth_multiplier #(.WIDTH(16)) dut16 (
    .Clock(clk), .Reset_n(rst_n), .Start(start16), .Signed_Mode(sm16),
    .Multiplicand(a16), .Multiplier(b16), .Product(prod16), .Done(done16), .Busy(busy16)
  );

  booth_multiplier #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset_n(rst_n), .Start(start8), .Signed_Mode(sm8),
    .Multiplicand(a8), .Multiplier(b8), .Product(prod8), .Done(done8), .Busy(busy8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model16(input logic s, input logic [15:0] a,
                                          input logic [15:0] b);
    longint sa, sb, p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    p = sa * sb;
    return p[31:0];
  endfunction

  // Launch one op, scramble inputs after the Start edge, wait for Done (bounded)
  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                      output int lat, output int busy_cyc);
    @(negedge clk);
    start16 = 1'b1; sm16 = s; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = ~s;
    lat = 0; busy_cyc = 0;
    while (!done16 && lat < 50) begin
      if (busy16) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output int lat);
    @(negedge clk);
    start8 = 1'b1; sm8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bc, ndone, first, g;
    logic s;
    logic [15:0] ra, rb;

    vecs[0]  = '{1'b1, 16'd12,    16'd10,    32'd120};
    vecs[1]  = '{1'b1, 16'hFFF4,  16'd10,    32'hFFFF_FF88};
    vecs[2]  = '{1'b1, 16'hFFFF,  16'hFFFF,  32'd1};
    vecs[3]  = '{1'b1, 16'h8000,  16'd1,     32'hFFFF_8000};
    vecs[4]  = '{1'b1, 16'h8000,  16'h8000,  32'h4000_0000};
    vecs[5]  = '{1'b1, 16'hCFC7,  16'hA460,  32'd289564320};
    vecs[6]  = '{1'b0, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001};
    vecs[7]  = '{1'b0, 16'h8000,  16'd2,     32'h0001_0000};
    vecs[8]  = '{1'b0, 16'd150,   16'd0,     32'd0};
    vecs[9]  = '{1'b0, 16'h8000,  16'h8000,  32'h4000_0000};
    vecs[10] = '{1'b1, 16'h7FFF,  16'h8000,  32'hC000_8000};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product16", prod16, 0);
    chk("reset_done16", done16, 0);
    chk("reset_busy16", busy16, 0);
    chk("reset_product8", prod8, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      op16(vecs[i].sm, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("vec%0d_product", i), prod16, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 9);
      chk($sformatf("vec%0d_busy_at_done", i), busy16, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), done16, 0);
      chk($sformatf("vec%0d_product_held", i), prod16, vecs[i].exp);
    end

    for (int i = 0; i < 30; i++) begin
      s  = 1'($urandom);
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
      op16(s, ra, rb, lat, bc);
      chk($sformatf("rand%0d_product", i), prod16, model16(s, ra, rb));
      chk($sformatf("rand%0d_latency", i), lat, 9);
    end

    // Start held high: relaunch as soon as the Done cycle is over
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b1; a16 = 16'hFFFD; b16 = 16'd7;
    g = 0;
    @(posedge clk); #1;
    while (!done16 && g < 50) begin @(posedge clk); #1; g++; end
    chk("held_first_latency", g, 9);
    g = 0;
    do begin @(posedge clk); #1; g++; end while (!done16 && g < 50);
    start16 = 1'b0;
    chk("held_gap", g, 10);
    chk("held_product", prod16, 32'hFFFF_FFEB);

    // Start re-pulsed mid-CALC with other operands must be ignored
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b1; a16 = 16'd12; b16 = 16'd10;
    @(posedge clk); #1;
    start16 = 1'b0;
    ndone = 0; first = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin start16 = 1'b1; a16 = 16'd7; b16 = 16'd7; end
      if (i == 4) start16 = 1'b0;
      @(posedge clk); #1;
      if (done16) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    chk("restart_done_count", ndone, 1);
    chk("restart_done_edge", first, 9);
    chk("restart_product", prod16, 120);

    // Asynchronous reset mid-CALC aborts the operation
    @(negedge clk);
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_product", prod16, 0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done16) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    op16(1'b0, 16'h1234, 16'h5678, lat, bc);
    chk("after_abort_product", prod16, model16(1'b0, 16'h1234, 16'h5678));
    chk("after_abort_latency", lat, 9);

    op8(1'b1, 8'h80, 8'h80, lat);
    chk("w8_signed_product", prod8, 16'h4000);
    chk("w8_signed_latency", lat, 5);
    chk("w8_busy_at_done", busy8, 0);
    op8(1'b0, 8'hFF, 8'hFF, lat);
    chk("w8_unsigned_product", prod8, 16'hFE01);
    chk("w8_unsigned_latency", lat, 5);
    op8(1'b1, 8'hF6, 8'h07, lat);
    chk("w8_signed_mixed_product", prod8, 16'hFFBA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
